// File: rtl/bldc_pkg.sv
// ============================================================================
// Module      : bldc_pkg
// Description : Shared types and constants for the BLDC open-loop start-up path
// Revision    : 1.0
// ============================================================================
`default_nettype none

package bldc_pkg;

    localparam int unsigned c_MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RAMP  = 2'd2,
        ST_RUN   = 2'd3
    } bldc_ramp_state_e;

    typedef struct packed {
        logic align;
        logic running;
    } bldc_status_t;

endpackage

`default_nettype wire

// File: rtl/bldc_period_cnt.sv
// ============================================================================
// Module      : bldc_period_cnt
// Description : Up-counter wrapping at period-1 with a registered wrap pulse
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bldc_period_cnt
    import bldc_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             run_i,
    input  logic             pulse_en_i,
    input  logic             kick_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             last_o,
    output logic             wrap_o
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_wrap;
    logic             w_last;

    assign w_last = run_i && (r_cnt == (period_i - CNT_W'(1)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            if (clr_i || w_last) begin
                r_cnt <= '0;
            end else if (run_i) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // kick forces a pulse even while the count is being cleared
            r_wrap <= kick_i | (w_last & pulse_en_i & ~clr_i);
        end
    end

    assign last_o = w_last;
    assign wrap_o = r_wrap;

endmodule

`default_nettype wire

// File: rtl/bldc_ol_ramp.sv
// ============================================================================
// Module      : bldc_ol_ramp
// Description : Open-loop BLDC start-up: align strobe, hold, period ramp, run
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bldc_ol_ramp
    import bldc_pkg::*;
#(
    parameter int CNT_W      = 24,
    parameter int MIN_PERIOD = c_MIN_PERIOD
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ena_i,
    input  logic [CNT_W-1:0] start_period_i,
    input  logic [CNT_W-1:0] target_period_i,
    input  logic [CNT_W-1:0] step_i,
    input  logic [CNT_W-1:0] align_cycles_i,
    output logic             phase_jump_o,
    output logic             align_o,
    output logic             running_o,
    output logic [CNT_W-1:0] period_o
);

    localparam logic [CNT_W-1:0] c_MIN_P = CNT_W'(MIN_PERIOD);

    function automatic logic [CNT_W-1:0] f_max(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    bldc_ramp_state_e r_state;
    bldc_ramp_state_e w_state_nxt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] w_period_nxt;
    logic [CNT_W-1:0] r_align_len;
    logic [CNT_W-1:0] w_align_len_nxt;
    bldc_status_t     r_status;
    bldc_status_t     w_status_nxt;

    logic [CNT_W-1:0] w_target;
    logic [CNT_W:0]   w_diff;
    logic [CNT_W-1:0] w_ramp_nxt;

    logic             w_clr;
    logic             w_run;
    logic             w_pulse_en;
    logic             w_kick;
    logic [CNT_W-1:0] w_cnt_period;
    logic             w_last;
    logic             w_wrap;

    assign w_target   = f_max(target_period_i, c_MIN_P);
    // one extra bit so a step larger than the period shows up as underflow
    assign w_diff     = {1'b0, r_period} - {1'b0, step_i};
    assign w_ramp_nxt = (w_diff[CNT_W] || (w_diff[CNT_W-1:0] < w_target)) ?
                        w_target : w_diff[CNT_W-1:0];

    bldc_period_cnt #(
        .CNT_W (CNT_W)
    ) u_period_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (w_clr),
        .run_i      (w_run),
        .pulse_en_i (w_pulse_en),
        .kick_i     (w_kick),
        .period_i   (w_cnt_period),
        .last_o     (w_last),
        .wrap_o     (w_wrap)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_period    <= '0;
            r_align_len <= '0;
            r_status    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_period    <= w_period_nxt;
            r_align_len <= w_align_len_nxt;
            r_status    <= w_status_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_period_nxt    = r_period;
        w_align_len_nxt = r_align_len;
        w_clr           = 1'b0;
        w_run           = 1'b0;
        w_pulse_en      = 1'b0;
        w_kick          = 1'b0;
        w_cnt_period    = r_period;

        unique case (r_state)
            ST_IDLE: begin
                w_clr        = 1'b1;
                w_period_nxt = '0;
                if (ena_i) begin
                    w_state_nxt     = ST_ALIGN;
                    w_kick          = 1'b1;
                    w_align_len_nxt = (align_cycles_i == '0) ? CNT_W'(1) : align_cycles_i;
                end
            end
            ST_ALIGN: begin
                w_run        = 1'b1;
                w_cnt_period = r_align_len;
                if (w_last) begin
                    w_state_nxt  = ST_RAMP;
                    w_period_nxt = f_max(start_period_i, w_target);
                end
            end
            ST_RAMP: begin
                w_run      = 1'b1;
                w_pulse_en = 1'b1;
                if (w_last) begin
                    w_period_nxt = w_ramp_nxt;
                    if (w_ramp_nxt == w_target) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                w_run      = 1'b1;
                w_pulse_en = 1'b1;
                if (w_last) begin
                    w_period_nxt = w_target;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // disable wins over any transition, including a coinciding wrap
        if (!ena_i) begin
            w_state_nxt  = ST_IDLE;
            w_period_nxt = '0;
            w_clr        = 1'b1;
            w_run        = 1'b0;
            w_pulse_en   = 1'b0;
            w_kick       = 1'b0;
        end

        w_status_nxt.align   = (w_state_nxt == ST_ALIGN);
        w_status_nxt.running = (w_state_nxt == ST_RUN);
    end

    assign phase_jump_o = w_wrap;
    assign align_o      = r_status.align;
    assign running_o    = r_status.running;
    assign period_o     = r_period;

endmodule

`default_nettype wire

// File: tb/tb_bldc_ol_ramp.sv
// ============================================================================
// Module      : tb_bldc_ol_ramp
// Description : Scoreboard bench for bldc_ol_ramp strobe timing and periods
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_bldc_ol_ramp;

    localparam int CNT_W = 24;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             ena_i = 1'b0;
    logic [CNT_W-1:0] start_period_i = '0;
    logic [CNT_W-1:0] target_period_i = '0;
    logic [CNT_W-1:0] step_i = '0;
    logic [CNT_W-1:0] align_cycles_i = '0;
    logic             phase_jump_o;
    logic             align_o;
    logic             running_o;
    logic [CNT_W-1:0] period_o;

    bldc_ol_ramp #(
        .CNT_W      (CNT_W),
        .MIN_PERIOD (2)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .ena_i           (ena_i),
        .start_period_i  (start_period_i),
        .target_period_i (target_period_i),
        .step_i          (step_i),
        .align_cycles_i  (align_cycles_i),
        .phase_jump_o    (phase_jump_o),
        .align_o         (align_o),
        .running_o       (running_o),
        .period_o        (period_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          edge_no;
        int unsigned period;
        logic        running;
        logic        align;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   edge_cnt     = 0;
    int   base         = 0;
    logic prev_pj      = 1'b0;

    always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

    // Monitor: every strobe is matched against the next expected entry
    always @(negedge clk_i) begin
        exp_t e;
        if (phase_jump_o) begin
            tests_run++;
            if (prev_pj) begin
                tests_failed++;
                $display("FAIL strobe_b2b: strobe at edge %0d directly follows another, required isolated", edge_cnt);
            end else if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL strobe_unexpected: strobe at edge %0d period=%0d, required no strobe", edge_cnt, period_o);
            end else begin
                e = exp_q.pop_front();
                if (e.edge_no != edge_cnt || period_o != CNT_W'(e.period) ||
                    running_o != e.running || align_o != e.align) begin
                    tests_failed++;
                    $display("FAIL strobe: got edge=%0d period=%0d run=%0b align=%0b, required edge=%0d period=%0d run=%0b align=%0b",
                             edge_cnt, period_o, running_o, align_o,
                             e.edge_no, e.period, e.running, e.align);
                end
            end
        end
        prev_pj = phase_jump_o;
    end

    task automatic chk(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic expect_strobe(input int cyc, input int unsigned per, input logic run, input logic al);
        exp_t e;
        e.edge_no = base + cyc - 1;
        e.period  = per;
        e.running = run;
        e.align   = al;
        exp_q.push_back(e);
    endtask

    task automatic go(input int unsigned s, input int unsigned t, input int unsigned st, input int unsigned a);
        @(negedge clk_i);
        start_period_i  = CNT_W'(s);
        target_period_i = CNT_W'(t);
        step_i          = CNT_W'(st);
        align_cycles_i  = CNT_W'(a);
        ena_i           = 1'b1;
        base            = edge_cnt + 1;
    endtask

    // returns at the negedge inside cycle c of the current run
    task automatic wait_cyc(input int c);
        while (edge_cnt < base + c - 1) @(negedge clk_i);
    endtask

    task automatic stop_run();
        ena_i = 1'b0;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_pj"},     CNT_W'(phase_jump_o), '0);
        chk({tag, "_align"},  CNT_W'(align_o),      '0);
        chk({tag, "_run"},    CNT_W'(running_o),    '0);
        chk({tag, "_period"}, period_o,             '0);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        chk_idle("reset");
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        chk_idle("idle");

        // nominal ramp 10 -> 7 -> 4
        go(10, 4, 3, 5);
        expect_strobe(1, 0, 1'b0, 1'b1);
        expect_strobe(16, 7, 1'b0, 1'b0);
        expect_strobe(23, 4, 1'b1, 1'b0);
        expect_strobe(27, 4, 1'b1, 1'b0);
        expect_strobe(31, 4, 1'b1, 1'b0);
        wait_cyc(5);
        chk("align_held", CNT_W'(align_o), CNT_W'(1));
        wait_cyc(6);
        chk("ramp_entry_period", period_o, CNT_W'(10));
        chk("ramp_entry_align", CNT_W'(align_o), '0);

        // disable sampled at the RUN wrap edge (cnt = period-1 in cycle 34)
        wait_cyc(34);
        ena_i = 1'b0;
        wait_cyc(35);
        chk_idle("disable_at_wrap");
        ena_i = 1'b1;
        base  = edge_cnt + 1;
        expect_strobe(1, 0, 1'b0, 1'b1);

        // async reset in the middle of RAMP
        wait_cyc(10);
        chk("pre_reset_period", period_o, CNT_W'(10));
        #1 rst_ni = 1'b0;
        #1 chk_idle("async_reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        base   = edge_cnt + 1;
        expect_strobe(1, 0, 1'b0, 1'b1);
        expect_strobe(16, 7, 1'b0, 1'b0);
        expect_strobe(23, 4, 1'b1, 1'b0);
        wait_cyc(23);
        stop_run();

        // underflow saturates at target
        go(6, 3, 10, 2);
        expect_strobe(1, 0, 1'b0, 1'b1);
        expect_strobe(9, 3, 1'b1, 1'b0);
        expect_strobe(12, 3, 1'b1, 1'b0);
        expect_strobe(15, 3, 1'b1, 1'b0);
        wait_cyc(3);
        chk("uf_ramp_period", period_o, CNT_W'(6));
        wait_cyc(15);
        stop_run();

        // clamp: align 0 -> 1 cycle, periods clamped to 2
        go(1, 0, 0, 0);
        expect_strobe(1, 0, 1'b0, 1'b1);
        expect_strobe(4, 2, 1'b1, 1'b0);
        expect_strobe(6, 2, 1'b1, 1'b0);
        expect_strobe(8, 2, 1'b1, 1'b0);
        wait_cyc(2);
        chk("clamp_align_done", CNT_W'(align_o), '0);
        chk("clamp_period", period_o, CNT_W'(2));
        wait_cyc(8);
        stop_run();

        // retarget 8 -> 5 mid-interval
        go(8, 8, 1, 1);
        expect_strobe(1, 0, 1'b0, 1'b1);
        expect_strobe(10, 8, 1'b1, 1'b0);
        expect_strobe(18, 5, 1'b1, 1'b0);
        expect_strobe(23, 5, 1'b1, 1'b0);
        expect_strobe(28, 5, 1'b1, 1'b0);
        wait_cyc(14);
        target_period_i = CNT_W'(5);
        chk("retarget_hold", period_o, CNT_W'(8));
        wait_cyc(28);
        stop_run();

        repeat (5) @(negedge clk_i);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL missing_strobes: %0d expected strobes never seen, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
